seg_scan_ctrl: RTL

//  Parametrised multiplexed 7-segment scanner; successor to the fixed 8-digit display path.

---
 rtl/seg_scan_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Multiplexed 7-segment scanner for DIGITS hex digits. It steps through one
//   digit per slot of CLK_DIV clocks. The number, decimal points and
//   leading-zero enable are captured once per frame, so the display never
//   shows a half-updated value. Brightness is set by PWM across the
//   2**DUTY_W slices of each slot.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous reset, active-high
//   enable_i      in   1 = display on; 0 = dark while scanning continues
//   number_i      in   4*DIGITS hex digits, digit 0 = number_i[3:0] (rightmost)
//   dp_en_i       in   DIGITS decimal-point enables
//   lz_blank_i    in   1 = blank leading zero digits (digit 0 never blanked)
//   brightness_i  in   DUTY_W, anode lit for (brightness_i+1) slices of a slot
//   an_o          out  DIGITS anode selects, active-low
//   patt_o        out  {dp,g,f,e,d,c,b,a}, active-low
//   digit_idx_o   out  index of the digit currently being scanned
//   frame_tick_o  out  1-cycle pulse on the first cycle a new snapshot is held
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter  int DIGITS  = 8,
    parameter  int CLK_DIV = 1024,
    parameter  int DUTY_W  = 3,
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic [4*DIGITS-1:0]   number_i,
    input  logic [DIGITS-1:0]     dp_en_i,
    input  logic                  lz_blank_i,
    input  logic [DUTY_W-1:0]     brightness_i,
    output logic [DIGITS-1:0]     an_o,
    output logic [7:0]            patt_o,
    output logic [IDX_W-1:0]      digit_idx_o,
    output logic                  frame_tick_o
);
    localparam int CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SLICE_LEN = CLK_DIV >> DUTY_W;
    localparam int SUB_W     = (SLICE_LEN > 1) ? $clog2(SLICE_LEN) : 1;

    // Segment patterns {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] seg7(input logic [3:0] h);
        case (h)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h18;
            4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    logic [CNT_W-1:0]    pre_cnt_q,   pre_cnt_d;
    logic [SUB_W-1:0]    sub_cnt_q,   sub_cnt_d;
    logic [DUTY_W-1:0]   slice_q,     slice_d;
    logic [IDX_W-1:0]    digit_idx_q, digit_idx_d;
    logic                first_q;
    logic [4*DIGITS-1:0] num_snap_q;
    logic [DIGITS-1:0]   dp_snap_q;
    logic                lz_snap_q;
    logic [DIGITS-1:0]   an_q,        an_d;
    logic [7:0]          patt_q,      patt_d;
    logic                frame_tick_q;

    logic slot_end, slice_end, frame_end, take_snap;

    assign slot_end  = (pre_cnt_q == CNT_W'(CLK_DIV - 1));
    assign slice_end = (sub_cnt_q == SUB_W'(SLICE_LEN - 1));
    assign frame_end = slot_end && (digit_idx_q == IDX_W'(DIGITS - 1));
    // The first cycle out of reset also captures a snapshot, so the scan
    // restarts with current inputs rather than the cleared shadow values.
    assign take_snap = first_q || frame_end;

    // On the first cycle after reset the shadow registers are still cleared.
    // The digit being registered on that cycle therefore reads the inputs
    // directly, which are exactly what the snapshot is capturing.
    logic [4*DIGITS-1:0] disp_num;
    logic [DIGITS-1:0]   disp_dp;
    logic                disp_lz;
    assign disp_num = first_q ? number_i   : num_snap_q;
    assign disp_dp  = first_q ? dp_en_i    : dp_snap_q;
    assign disp_lz  = first_q ? lz_blank_i : lz_snap_q;

    // Leading-zero mask. zero_above[i] is set when digits DIGITS-1..i are all zero.
    logic [3:0]        nib [DIGITS];
    logic [DIGITS:1]   zero_above;
    logic [DIGITS-1:0] blank_vec;

    assign zero_above[DIGITS] = 1'b1;
    assign blank_vec[0]       = 1'b0;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign nib[gi] = disp_num[4*gi +: 4];
        end
        for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lz
            assign zero_above[gi] = (nib[gi] == 4'h0) && zero_above[gi+1];
            assign blank_vec[gi]  = disp_lz && zero_above[gi];
        end
    endgenerate

    // Scan counters. The slice counter runs alongside pre_cnt so that
    // CLK_DIV does not have to be a power of two.
    always_comb begin
        pre_cnt_d   = slot_end ? '0 : pre_cnt_q + 1'b1;
        sub_cnt_d   = (slot_end || slice_end) ? '0 : sub_cnt_q + 1'b1;
        slice_d     = slot_end ? '0 : (slice_end ? slice_q + 1'b1 : slice_q);
        digit_idx_d = digit_idx_q;
        if (slot_end) begin
            digit_idx_d = frame_end ? '0 : digit_idx_q + 1'b1;
        end
    end

    // An anode and its pattern are registered from the same digit index.
    // They therefore always change on the same edge.
    logic lit;
    always_comb begin
        lit    = enable_i && (slice_q <= brightness_i);
        an_d   = '1;
        patt_d = 8'hFF;
        if (lit) begin
            an_d   = ~(DIGITS'(1) << digit_idx_q);
            patt_d = {~disp_dp[digit_idx_q],
                      blank_vec[digit_idx_q] ? 7'h7F : seg7(nib[digit_idx_q])};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q    <= '0;
            sub_cnt_q    <= '0;
            slice_q      <= '0;
            digit_idx_q  <= '0;
            first_q      <= 1'b1;
            num_snap_q   <= '0;
            dp_snap_q    <= '0;
            lz_snap_q    <= 1'b0;
            an_q         <= '1;
            patt_q       <= 8'hFF;
            frame_tick_q <= 1'b0;
        end else begin
            pre_cnt_q    <= pre_cnt_d;
            sub_cnt_q    <= sub_cnt_d;
            slice_q      <= slice_d;
            digit_idx_q  <= digit_idx_d;
            first_q      <= 1'b0;
            an_q         <= an_d;
            patt_q       <= patt_d;
            // The pulse marks the first cycle the freshly loaded snapshot is held.
            frame_tick_q <= take_snap;
            if (take_snap) begin
                num_snap_q <= number_i;
                dp_snap_q  <= dp_en_i;
                lz_snap_q  <= lz_blank_i;
            end
        end
    end

    assign an_o         = an_q;
    assign patt_o       = patt_q;
    assign digit_idx_o  = digit_idx_q;
    assign frame_tick_o = frame_tick_q;

endmodule
